// File: rtl/inst_fetch_pkg.sv
// inst_fetch shared package: NOP encoding, FSM states, PC step,
// and the 64-bit prefetch queue entry (PC + instruction word).
`timescale 1ns/1ps
package inst_fetch_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: synchronous FIFO of {pc, inst} entries, DEPTH a power
// of two. Ports: i_clk, i_rst (sync, high), i_push/i_data, i_pop,
// i_flush (empties queue, overrides push/pop), o_head (registered
// storage at read pointer), o_count (occupancy).
`timescale 1ns/1ps
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  fq_entry_t              i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fq_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_cnt;
  logic            w_push;
  logic            w_pop;

  assign w_push = i_push && (r_cnt != (AW+1)'(DEPTH));
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{pc: 32'h0, inst: NOP};
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, 1-cycle-latency imem reads, 2-entry prefetch
// queue, valid/ready delivery, redirect flush. Ports: i_clk, i_rst,
// o_mem_req/o_mem_addr/i_mem_rdata, o_inst/o_inst_pc/o_inst_valid,
// i_inst_ready, i_redirect/i_redirect_pc, o_misalign.
// Option: FETCH_MISALIGN_TRAP_EN halts on a misaligned redirect target.
`timescale 1ns/1ps
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_misalign
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [31:0] w_redir_pc;
  logic [CW-1:0] w_count;
  logic [CW:0] w_occ;
  fq_entry_t   w_head;
  fq_entry_t   w_push_data;
  logic        w_push;
  logic        w_pop;
  logic        w_issue;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = i_redirect_pc[1:0] != 2'b00;
  assign w_redir_pc   = i_redirect_pc;
  assign o_misalign   = r_state == HALT;
`else
  assign w_redir_pc   = i_redirect_pc & ~32'h3;
  assign o_misalign   = 1'b0;
`endif

  assign w_pop  = o_inst_valid && i_inst_ready && !i_redirect;
  assign w_push = r_inflight && !i_redirect;
  assign w_push_data = '{pc: r_inflight_pc, inst: i_mem_rdata};

  // A head popped this cycle frees its slot for a request issued now,
  // which keeps one instruction per cycle with a 2-entry queue.
  assign w_occ = {1'b0, w_count}
               + (CW+1)'(r_inflight)
               - (CW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (i_redirect) begin
      w_state_nxt = w_misaligned ? HALT : RUN;
    end
`endif
    unique case (r_state)
      RUN:  w_issue = !i_redirect && (w_occ < (CW+1)'(QUEUE_DEPTH));
      HALT: w_issue = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_inflight    <= o_mem_req;
      r_inflight_pc <= r_fetch_pc;
      if (i_redirect) begin
        r_fetch_pc <= w_redir_pc;
      end else if (o_mem_req) begin
        r_fetch_pc <= r_fetch_pc + PC_INC;
      end
    end
  end

  inst_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign o_mem_req    = w_issue && !i_rst;
  assign o_mem_addr   = r_fetch_pc;
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;
  assign o_inst_valid = w_count != '0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch (RESET_PC = 0x100).
// Requests push expected {pc, word}; delivered heads pop and compare.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC    (32'h100),
    .QUEUE_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_rdata   (mem_rdata),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .o_inst_valid  (inst_valid),
    .i_inst_ready  (ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_misalign    (misalign)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Instruction memory: data valid exactly one cycle after the request.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? memf(mem_addr) : 32'hDEAD_BEEF;
  end

  logic        p_hold = 1'b0;
  logic [31:0] p_inst;
  logic [31:0] p_pc;

  always @(negedge clk) begin
    exp_t e;
    if (p_hold) begin
      n_vec++;
      if (inst !== p_inst || inst_pc !== p_pc) begin
        n_err++;
        $display("FAIL hold: got %h@%h want %h@%h", inst, inst_pc, p_inst, p_pc);
      end
    end
    p_hold = !rst && !redirect && inst_valid && !ready;
    p_inst = inst;
    p_pc   = inst_pc;
    if (rst) begin
      sb.delete();
    end else if (redirect) begin
      sb.delete();
      n_vec++;
      if (mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL redirect_req: got %b want 0", mem_req);
      end
    end else begin
      if (inst_valid && ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: got pc %h want nothing", inst_pc);
        end else begin
          e = sb.pop_front();
          if (inst !== e.inst || inst_pc !== e.pc) begin
            n_err++;
            $display("FAIL sb_data: got %h@%h want %h@%h", inst, inst_pc, e.inst, e.pc);
          end
        end
      end
      if (mem_req) sb.push_back('{pc: mem_addr, inst: memf(mem_addr)});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (2) step();
    @(negedge clk);
    n_vec += 6;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
    if (mem_addr !== 32'h100) begin n_err++; $display("FAIL rst_addr: got %h want 100", mem_addr); end
    if (inst !== 32'h13) begin n_err++; $display("FAIL rst_inst: got %h want 13", inst); end
    if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    if (misalign !== 1'b0) begin n_err++; $display("FAIL rst_mis: got %b want 0", misalign); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec += 2;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * k)) begin
        n_err++;
        $display("FAIL seq_req[%0d]: got %b/%h want 1/%h", k, mem_req, mem_addr, 32'h100 + 32'(4 * k));
      end
      if (inst_valid !== (k >= 2)) begin
        n_err++;
        $display("FAIL seq_valid[%0d]: got %b want %b", k, inst_valid, k >= 2);
      end
      if (k >= 2) begin
        n_vec++;
        if (inst_pc !== 32'h100 + 32'(4 * (k - 2))) begin
          n_err++;
          $display("FAIL seq_pc[%0d]: got %h want %h", k, inst_pc, 32'h100 + 32'(4 * (k - 2)));
        end
      end
      step();
    end
  endtask

  task automatic test_stall;
    int reqs;
    reqs = 0;
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reqs += int'(mem_req);
      step();
    end
    @(negedge clk);
    n_vec += 3;
    if (reqs != 2) begin n_err++; $display("FAIL stall_reqs: got %0d want 2", reqs); end
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", mem_req); end
    if (inst_valid !== 1'b1 || inst_pc !== 32'h400 || inst !== memf(32'h400)) begin
      n_err++;
      $display("FAIL stall_head: got %b %h@%h want 1 %h@400", inst_valid, inst, inst_pc, memf(32'h400));
    end
    step();
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h400 + 32'(4 * k)) begin
        n_err++;
        $display("FAIL resume_pc[%0d]: got %b/%h want 1/%h", k, inst_valid, inst_pc, 32'h400 + 32'(4 * k));
      end
      if (k == 0) begin
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h408) begin
          n_err++;
          $display("FAIL resume_req: got %b/%h want 1/408", mem_req, mem_addr);
        end
      end
      step();
    end
  endtask

  task automatic test_redirect;
    logic [31:0] tgt;
    for (int m = 0; m < 2; m++) begin
      tgt = 32'h2000 + 32'(m * 32'h1000);
      ready = (m == 1);
      repeat (4) step();
      redirect = 1'b1; redirect_pc = tgt;
      step();
      redirect = 1'b0; ready = 1'b1;
      @(negedge clk);
      n_vec += 2;
      if (mem_req !== 1'b1 || mem_addr !== tgt) begin
        n_err++;
        $display("FAIL redir_req[%0d]: got %b/%h want 1/%h", m, mem_req, mem_addr, tgt);
      end
      if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_v1[%0d]: got %b want 0", m, inst_valid); end
      step();
      @(negedge clk);
      n_vec++;
      if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_v2[%0d]: got %b want 0", m, inst_valid); end
      step();
      @(negedge clk);
      n_vec++;
      if (inst_valid !== 1'b1 || inst_pc !== tgt) begin
        n_err++;
        $display("FAIL redir_first[%0d]: got %b/%h want 1/%h", m, inst_valid, inst_pc, tgt);
      end
      step();
      repeat (3) step();
    end
  endtask

  task automatic test_wrap;
    logic [31:0] ea;
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ea = 32'hFFFF_FFF8 + 32'(4 * k);
      @(negedge clk);
      n_vec++;
      if (mem_req !== 1'b1 || mem_addr !== ea) begin
        n_err++;
        $display("FAIL wrap_addr[%0d]: got %b/%h want 1/%h", k, mem_req, mem_addr, ea);
      end
      step();
    end
    repeat (4) step();
  endtask

  task automatic test_misalign;
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2002;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (misalign !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL halt[%0d]: got mis/req/v %b%b%b want 100", k, misalign, mem_req, inst_valid);
      end
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_vec++;
    if (misalign !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h3000) begin
      n_err++;
      $display("FAIL unhalt: got %b %b/%h want 0 1/3000", misalign, mem_req, mem_addr);
    end
`else
    @(negedge clk);
    n_vec++;
    if (misalign !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h2000) begin
      n_err++;
      $display("FAIL align_force: got %b %b/%h want 0 1/2000", misalign, mem_req, mem_addr);
    end
`endif
    step();
    repeat (4) step();
  endtask

  task automatic test_reset_mid;
    ready = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    n_vec++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h100 || inst !== 32'h13) begin
      n_err++;
      $display("FAIL midrst: got v%b r%b %h %h want v0 r0 100 13", inst_valid, mem_req, mem_addr, inst);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_vec += 2;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL midrst_req: got %b/%h want 1/100", mem_req, mem_addr);
    end
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_v0: got %b want 0", inst_valid); end
    step();
    @(negedge clk);
    n_vec++;
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_v1: got %b want 0", inst_valid); end
    step();
    @(negedge clk);
    n_vec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
      n_err++;
      $display("FAIL midrst_first: got %b/%h want 1/100", inst_valid, inst_pc);
    end
    step();
    repeat (5) step();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit feeding the core's 32-bit instruction input. It holds the fetch PC and issues word reads to a synchronous instruction memory with fixed 1-cycle read latency. Returned words are buffered in a 2-entry prefetch queue and delivered to the core over a valid/ready handshake. A redirect input (branch/jump target from the core) flushes all queued and in-flight fetches and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 2, prefetch entries (fixed power of two, ≥2)

- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- o_mem_req  output  1  read strobe to instruction memory
- o_mem_addr  output  32  byte address, bits [1:0] always 0
- i_mem_rdata  input  32  read data, valid exactly 1 cycle after o_mem_req
- o_inst  output  32  instruction at queue head
- o_inst_pc  output  32  PC of o_inst
- o_inst_valid  output  1  queue head valid
- i_inst_ready  input  1  core accepts head this cycle
- i_redirect  input  1  flush and restart fetch
- i_redirect_pc  input  32  new fetch PC
- o_misalign  output  1  redirect target misaligned (macro-dependent)

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- Issue rule: in RUN with no i_redirect, assert o_mem_req when queue count + in-flight count < QUEUE_DEPTH; o_mem_addr = fetch_pc; fetch_pc += 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
- Response: cycle after an issue, i_mem_rdata and its PC are pushed into the queue unless killed.
- Pop: o_inst_valid && i_inst_ready removes head.
- Redirect (any state): queue emptied, in-flight response killed, fetch_pc = i_redirect_pc; no o_mem_req that cycle; issue resumes next cycle.
- Redirect + pop same cycle: redirect wins; pop has no further effect.
- Redirect + response same cycle: response discarded.
- Queue full: no issue; in-flight accounting guarantees no overflow.
- Reset values: o_mem_req 0, o_mem_addr RESET_PC, o_inst 32'h0000_0013 (NOP), o_inst_pc 0, o_inst_valid 0, o_misalign 0, fetch_pc RESET_PC, queue empty.
- Reset mid-operation: everything returns to reset values next cycle; pending response dropped.

## Timing
- Fetch-to-valid latency: 2 cycles from o_mem_req to o_inst_valid on an empty queue (request cycle N, data cycle N+1, head valid N+2).
- Sustained throughput: one instruction per cycle with i_inst_ready held high.
- Redirect penalty: redirect cycle R, first request R+1, first valid R+3.
- o_inst/o_inst_pc registered; hold stable while o_inst_valid && !i_inst_ready.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with i_redirect_pc[1:0] != 0 → HALT, o_misalign = 1, no requests, queue empty; an aligned redirect → RUN, o_misalign = 0.
- Undefined: i_redirect_pc[1:0] forced to 0, HALT unreachable, o_misalign tied 0.

## Structure
- Shared package: NOP encoding 32'h0000_0013, FSM state encoding, PC increment constant 4.
- One sub-module: inst_fetch_queue (synchronous FIFO, data+PC 64-bit entries, push/pop/flush, count output).

## Test plan
- Reset with RESET_PC=32'h100, ready=1 → o_mem_addr 0x100,0x104,0x108…; o_inst_pc 0x100 valid 2 cycles after first req, then one per cycle.
- Hold i_inst_ready=0 → at most 2 requests issued, o_mem_req low afterwards, o_inst stable at PC 0x100; release → resumes, no loss or duplication.
- Redirect to 0x2000 while queue full and a read in flight → stale words never appear; next valid o_inst_pc is 0x2000 at R+3.
- Redirect coinciding with pop and with a returning response → no instruction from old stream delivered.
- fetch_pc at 0xFFFF_FFFC → next o_mem_addr 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x2002 → o_misalign=1, no o_mem_req; redirect to 0x3000 → o_misalign=0, fetch 0x3000. Without macro, redirect to 0x2002 fetches 0x2000.
